serv_mem_seq: RTL and testbench

SERV_MEM_SEQ -- requirements
Module: serv_mem_seq

---
 rtl/serv_mem_seq_pkg.sv | 31 +++
 rtl/serv_mem_sel.sv | 25 ++
 rtl/serv_mem_seq.sv | 158 +++++++++++++++
 tb/tb_serv_mem_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serv_mem_seq_pkg.sv
// rtl/serv_mem_seq_pkg.sv - shared types and constants for the serial memory sequencer
package serv_mem_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int TIMEOUT_DEFAULT        = 255;
  localparam int BITS_PER_CYCLE_DEFAULT = 8;

  // Top bit of the addressed datum inside a 32-bit bus word
  function automatic logic sign_bit(input logic [31:0] dat,
                                    input logic [1:0]  size,
                                    input logic [1:0]  lsb);
    logic r;
    case (size)
      SIZE_BYTE: r = dat[{lsb, 3'b111}];
      SIZE_HALF: r = lsb[1] ? dat[31] : dat[15];
      default:   r = dat[31];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serv_mem_sel.sv
// rtl/serv_mem_sel.sv - byte-lane select and alignment check for one access
module serv_mem_sel
  import serv_mem_seq_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] lsb,
  output logic [3:0] sel,
  output logic       misalign
);

  // Lane mask from size/offset; half needs even offset, word needs zero offset
  always_comb begin
    sel      = 4'b1111;
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: sel = 4'b0001 << lsb;
      SIZE_HALF: begin
        sel      = 4'b0011 << lsb;
        misalign = lsb[0];
      end
      default:   misalign = (lsb != 2'b00);
    endcase
  end

endmodule

// File: rtl/serv_mem_seq.sv
// rtl/serv_mem_seq.sv - sequences one load/store over a wishbone-style bus
module serv_mem_seq
  import serv_mem_seq_pkg::*;
#(
  parameter int BITS_PER_CYCLE = BITS_PER_CYCLE_DEFAULT,
  parameter int TIMEOUT        = TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_wdat,
  input  logic [1:0]  i_bytecnt,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic        o_load,
  output logic [31:0] o_rdat,
  output logic        o_sign,
  output logic        o_byte_valid,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4 ||
        BITS_PER_CYCLE == 8) || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("serv_mem_seq: unsupported BITS_PER_CYCLE or TIMEOUT");
  end

  // Counter value seen during the last BUS cycle allowed before abort
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] lsb_reg;
  logic [1:0] size_reg;
  logic [7:0] tmo_cnt;
  logic [3:0] req_sel;
  logic       req_misalign;
  logic       accept;
  logic       misalign_evt;
  logic       capture;
  logic       err_evt;

  serv_mem_sel u_sel (
    .size     (i_size),
    .lsb      (i_adr[1:0]),
    .sel      (req_sel),
    .misalign (req_misalign)
  );

  // Next state and transaction events; flush overrides everything, err beats ack
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    misalign_evt = 1'b0;
    capture      = 1'b0;
    err_evt      = 1'b0;
    if (i_flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            if (req_misalign) begin
              misalign_evt = 1'b1;
            end else begin
              accept    = 1'b1;
              state_nxt = ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (i_wb_err || (!i_wb_ack && tmo_cnt == TMO_LAST)) begin
            err_evt   = 1'b1;
            state_nxt = ST_IDLE;
          end else if (i_wb_ack) begin
            if (o_wb_we) begin
              state_nxt = ST_DONE;
            end else begin
              capture   = 1'b1;
              state_nxt = ST_CAPT;
            end
          end
        end
        ST_CAPT: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Bus request registers, timeout counter, captured read data and event pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_adr   <= 32'h0;
      o_wb_dat   <= 32'h0;
      o_wb_sel   <= 4'h0;
      lsb_reg    <= 2'b00;
      size_reg   <= 2'b00;
      tmo_cnt    <= 8'h0;
      o_rdat     <= 32'h0;
      o_sign     <= 1'b0;
      o_misalign <= 1'b0;
      o_bus_err  <= 1'b0;
    end else begin
      o_misalign <= misalign_evt;
      o_bus_err  <= err_evt;
      if (accept) begin
        o_wb_cyc <= 1'b1;
        o_wb_stb <= 1'b1;
        o_wb_we  <= i_we;
        o_wb_adr <= {i_adr[31:2], 2'b00};
        o_wb_dat <= i_wdat;
        o_wb_sel <= req_sel;
        lsb_reg  <= i_adr[1:0];
        size_reg <= i_size;
        tmo_cnt  <= 8'h0;
      end else if (state == ST_BUS) begin
        if (state_nxt != ST_BUS) begin
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
        end
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (capture) begin
        o_rdat <= i_wb_rdt;
        o_sign <= sign_bit(i_wb_rdt, size_reg, lsb_reg) & i_signed;
      end
    end
  end

  assign o_busy       = (state != ST_IDLE);
  assign o_load       = (state == ST_CAPT);
  assign o_done       = (state == ST_DONE);
  assign o_byte_valid = (({1'b0, i_bytecnt} + {1'b0, lsb_reg}) <= 3'd3);

endmodule

// File: tb/tb_serv_mem_seq.sv
// tb/tb_serv_mem_seq.sv - directed self-checking bench for serv_mem_seq
module tb_serv_mem_seq;

  logic        i_clk, i_rst_n, i_req, i_we, i_signed, i_flush;
  logic [1:0]  i_size, i_bytecnt;
  logic [31:0] i_adr, i_wdat, i_wb_rdt;
  logic        i_wb_ack, i_wb_err;
  logic        o_busy, o_done, o_misalign, o_bus_err, o_load, o_sign, o_byte_valid;
  logic [31:0] o_rdat, o_wb_adr, o_wb_dat;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_sel;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rdat;

  serv_mem_seq #(.BITS_PER_CYCLE(8), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_signed(i_signed), .i_adr(i_adr), .i_wdat(i_wdat), .i_bytecnt(i_bytecnt),
    .i_flush(i_flush), .o_busy(o_busy), .o_done(o_done), .o_misalign(o_misalign),
    .o_bus_err(o_bus_err), .o_load(o_load), .o_rdat(o_rdat), .o_sign(o_sign),
    .o_byte_valid(o_byte_valid), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] adr, input logic [31:0] wdat);
    i_we = we; i_size = size; i_signed = sgn; i_adr = adr; i_wdat = wdat;
    i_req = 1'b1;
    step();
    i_req = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b000) begin n_bad++; $display("FAIL reset_wb_ctl: got %b want 000", {o_wb_cyc, o_wb_stb, o_wb_we}); end
    n_cmp++; if ({o_wb_adr, o_wb_dat, o_wb_sel} !== 68'h0) begin n_bad++; $display("FAIL reset_wb_data: got %h %h %h want 0", o_wb_adr, o_wb_dat, o_wb_sel); end
    n_cmp++; if ({o_rdat, o_sign} !== 33'h0) begin n_bad++; $display("FAIL reset_rdat_sign: got %h %b want 0", o_rdat, o_sign); end
    n_cmp++; if ({o_done, o_misalign, o_bus_err, o_load} !== 4'b0000) begin n_bad++; $display("FAIL reset_pulses: got %b want 0000", {o_done, o_misalign, o_bus_err, o_load}); end
    step();
    i_rst_n = 1'b1;
    step();
    exp_rdat = 32'h0;
  endtask

  task automatic test_word_load();
    start(1'b0, 2'b10, 1'b1, 32'h0000_0100, 32'h0);
    n_cmp++; if ({o_wb_cyc, o_wb_stb, o_wb_we, o_busy} !== 4'b1101) begin n_bad++; $display("FAIL wl_bus_ctl: got %b want 1101", {o_wb_cyc, o_wb_stb, o_wb_we, o_busy}); end
    n_cmp++; if (o_wb_sel !== 4'hF) begin n_bad++; $display("FAIL wl_sel: got %h want f", o_wb_sel); end
    n_cmp++; if (o_wb_adr !== 32'h100) begin n_bad++; $display("FAIL wl_adr: got %h want 00000100", o_wb_adr); end
    step();
    step();
    n_cmp++; if ({o_wb_cyc, o_load} !== 2'b10) begin n_bad++; $display("FAIL wl_wait: got cyc/load %b want 10", {o_wb_cyc, o_load}); end
    i_wb_ack = 1'b1; i_wb_rdt = 32'hDEAD_BEEF;
    step();
    i_wb_ack = 1'b0;
    exp_rdat = 32'hDEAD_BEEF;
    n_cmp++; if ({o_load, o_wb_cyc, o_wb_stb} !== 3'b100) begin n_bad++; $display("FAIL wl_capt: got load/cyc/stb %b want 100", {o_load, o_wb_cyc, o_wb_stb}); end
    n_cmp++; if (o_rdat !== exp_rdat) begin n_bad++; $display("FAIL wl_rdat: got %h want %h", o_rdat, exp_rdat); end
    n_cmp++; if (o_sign !== 1'b1) begin n_bad++; $display("FAIL wl_sign: got %b want 1", o_sign); end
    step();
    n_cmp++; if ({o_load, o_done} !== 2'b01) begin n_bad++; $display("FAIL wl_done: got load/done %b want 01", {o_load, o_done}); end
    step();
    n_cmp++; if ({o_busy, o_done, o_load} !== 3'b000) begin n_bad++; $display("FAIL wl_idle: got %b want 000", {o_busy, o_done, o_load}); end
    i_bytecnt = 2'd3;
    #1;
    n_cmp++; if (o_byte_valid !== 1'b1) begin n_bad++; $display("FAIL wl_bytevalid_cnt3: got %b want 1", o_byte_valid); end
    i_bytecnt = 2'd0;
  endtask

  task automatic test_load_latency();
    int cyc_n;
    cyc_n = 1;
    i_wb_ack = 1'b1; i_wb_rdt = 32'h7FFF_FFFF;
    start(1'b0, 2'b10, 1'b1, 32'h0000_0104, 32'h0);
    cyc_n++;
    for (int k = 0; k < 8 && !o_load; k++) begin
      step();
      cyc_n++;
    end
    i_wb_ack = 1'b0;
    exp_rdat = 32'h7FFF_FFFF;
    n_cmp++; if (cyc_n !== 3) begin n_bad++; $display("FAIL lat_cycles: o_load in cycle %0d want 3", cyc_n); end
    n_cmp++; if ({o_rdat, o_sign} !== {exp_rdat, 1'b0}) begin n_bad++; $display("FAIL lat_rdat_sign: got %h %b want %h 0", o_rdat, o_sign, exp_rdat); end
    step();
    step();
  endtask

  task automatic test_byte_load();
    start(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0);
    n_cmp++; if ({o_wb_sel, o_wb_adr} !== {4'b1000, 32'h200}) begin n_bad++; $display("FAIL bl_sel_adr: got %b %h want 1000 00000200", o_wb_sel, o_wb_adr); end
    i_wb_ack = 1'b1; i_wb_rdt = 32'h8000_0000;
    step();
    i_wb_ack = 1'b0;
    exp_rdat = 32'h8000_0000;
    n_cmp++; if ({o_load, o_sign} !== 2'b11) begin n_bad++; $display("FAIL bl_signed: got load/sign %b want 11", {o_load, o_sign}); end
    step();
    step();
    i_bytecnt = 2'd0;
    #1;
    n_cmp++; if (o_byte_valid !== 1'b1) begin n_bad++; $display("FAIL bv_lsb3_cnt0: got %b want 1", o_byte_valid); end
    i_bytecnt = 2'd1;
    #1;
    n_cmp++; if (o_byte_valid !== 1'b0) begin n_bad++; $display("FAIL bv_lsb3_cnt1: got %b want 0", o_byte_valid); end
    i_bytecnt = 2'd0;
    start(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0);
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    n_cmp++; if ({o_load, o_sign, o_rdat} !== {2'b10, exp_rdat}) begin n_bad++; $display("FAIL bl_unsigned: got load/sign %b rdat %h want 10 %h", {o_load, o_sign}, o_rdat, exp_rdat); end
    step();
    step();
  endtask

  task automatic test_half_store();
    start(1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'hABCD_0000);
    n_cmp++; if ({o_wb_cyc, o_wb_we, o_wb_sel} !== 6'b11_1100) begin n_bad++; $display("FAIL hs_ctl_sel: got cyc/we %b sel %b want 11 1100", {o_wb_cyc, o_wb_we}, o_wb_sel); end
    n_cmp++; if ({o_wb_dat, o_wb_adr} !== {32'hABCD_0000, 32'h0}) begin n_bad++; $display("FAIL hs_dat_adr: got %h %h want abcd0000 00000000", o_wb_dat, o_wb_adr); end
    i_wb_ack = 1'b1;
    step();
    i_wb_ack = 1'b0;
    n_cmp++; if ({o_done, o_load, o_wb_cyc} !== 3'b100) begin n_bad++; $display("FAIL hs_done: got done/load/cyc %b want 100", {o_done, o_load, o_wb_cyc}); end
    step();
    n_cmp++; if ({o_busy, o_load} !== 2'b00) begin n_bad++; $display("FAIL hs_idle: got %b want 00", {o_busy, o_load}); end
  endtask

  task automatic test_misalign();
    start(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    n_cmp++; if ({o_misalign, o_wb_cyc, o_busy} !== 3'b100) begin n_bad++; $display("FAIL ma_word: got mis/cyc/busy %b want 100", {o_misalign, o_wb_cyc, o_busy}); end
    step();
    n_cmp++; if ({o_misalign, o_wb_cyc} !== 2'b00) begin n_bad++; $display("FAIL ma_pulse_end: got mis/cyc %b want 00", {o_misalign, o_wb_cyc}); end
    start(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0);
    n_cmp++; if ({o_misalign, o_wb_cyc} !== 2'b10) begin n_bad++; $display("FAIL ma_half: got mis/cyc %b want 10", {o_misalign, o_wb_cyc}); end
    step();
  endtask

  task automatic test_timeout();
    start(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
    step();
    step();
    step();
    n_cmp++; if ({o_wb_cyc, o_bus_err} !== 2'b10) begin n_bad++; $display("FAIL to_4th_cycle: got cyc/err %b want 10", {o_wb_cyc, o_bus_err}); end
    step();
    n_cmp++; if ({o_bus_err, o_wb_cyc, o_busy, o_load} !== 4'b1000) begin n_bad++; $display("FAIL to_abort: got err/cyc/busy/load %b want 1000", {o_bus_err, o_wb_cyc, o_busy, o_load}); end
    step();
    n_cmp++; if (o_bus_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse_end: got %b want 0", o_bus_err); end
  endtask

  task automatic test_ack_err();
    start(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
    i_wb_ack = 1'b1; i_wb_err = 1'b1; i_wb_rdt = 32'h1111_1111;
    step();
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
    n_cmp++; if ({o_bus_err, o_load, o_busy, o_wb_cyc} !== 4'b1000) begin n_bad++; $display("FAIL ae_err_wins: got err/load/busy/cyc %b want 1000", {o_bus_err, o_load, o_busy, o_wb_cyc}); end
    n_cmp++; if (o_rdat !== exp_rdat) begin n_bad++; $display("FAIL ae_rdat_kept: got %h want %h", o_rdat, exp_rdat); end
    step();
    n_cmp++; if ({o_done, o_load} !== 2'b00) begin n_bad++; $display("FAIL ae_no_done: got %b want 00", {o_done, o_load}); end
  endtask

  task automatic test_flush_ack();
    start(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0);
    i_wb_ack = 1'b1; i_flush = 1'b1; i_wb_rdt = 32'h2222_2222;
    step();
    i_wb_ack = 1'b0; i_flush = 1'b0;
    n_cmp++; if ({o_busy, o_wb_cyc, o_wb_stb, o_load, o_bus_err} !== 5'b00000) begin n_bad++; $display("FAIL fl_idle: got busy/cyc/stb/load/err %b want 00000", {o_busy, o_wb_cyc, o_wb_stb, o_load, o_bus_err}); end
    n_cmp++; if (o_rdat !== exp_rdat) begin n_bad++; $display("FAIL fl_rdat_kept: got %h want %h", o_rdat, exp_rdat); end
    step();
    n_cmp++; if ({o_done, o_load} !== 2'b00) begin n_bad++; $display("FAIL fl_no_done: got %b want 00", {o_done, o_load}); end
  endtask

  task automatic test_reset_in_bus();
    start(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    n_cmp++; if (o_wb_cyc !== 1'b1) begin n_bad++; $display("FAIL rb_cyc_before: got %b want 1", o_wb_cyc); end
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++; if ({o_wb_cyc, o_wb_stb, o_busy, o_wb_adr} !== 35'h0) begin n_bad++; $display("FAIL rb_async: got cyc/stb/busy %b adr %h want 000 0", {o_wb_cyc, o_wb_stb, o_busy}, o_wb_adr); end
    #2 i_rst_n = 1'b1;
    exp_rdat = 32'h0;
    step();
    n_cmp++; if ({o_busy, o_wb_cyc, o_rdat} !== 34'h0) begin n_bad++; $display("FAIL rb_lost: got busy/cyc %b rdat %h want 00 0", {o_busy, o_wb_cyc}, o_rdat); end
    start(1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0);
    n_cmp++; if ({o_wb_cyc, o_wb_adr} !== {1'b1, 32'h44}) begin n_bad++; $display("FAIL rb_first_req: got cyc %b adr %h want 1 00000044", o_wb_cyc, o_wb_adr); end
    i_wb_ack = 1'b1; i_wb_rdt = 32'h0000_5A5A;
    step();
    i_wb_ack = 1'b0;
    n_cmp++; if ({o_load, o_rdat} !== {1'b1, 32'h0000_5A5A}) begin n_bad++; $display("FAIL rb_load: got load %b rdat %h want 1 00005a5a", o_load, o_rdat); end
    step();
    step();
  endtask

  initial begin
    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_signed = 1'b0;
    i_adr = 32'h0; i_wdat = 32'h0; i_bytecnt = 2'd0; i_flush = 1'b0;
    i_wb_rdt = 32'h0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
    test_reset();
    test_word_load();
    test_load_latency();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_timeout();
    test_ack_err();
    test_flush_ack();
    test_reset_in_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
